// File: rtl/ssd_pkg.sv
// ssd_pkg
// Shared definitions for the seven-segment scan sequencer.
//  - scan_state_e    : per-slot FSM states (BLANK anti-ghost interval, SHOW)
//  - SEG_TABLE       : 16-entry hex -> segment table, active-high, bit order g..a
//  - seg_polarity    : maps active-high segments onto the board's segment polarity
//  - sel_polarity    : maps an active-high one-hot select onto the board's select polarity
// No ports; imported with "import ssd_pkg::*;".
package ssd_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   // Index = hex nibble, value = {g,f,e,d,c,b,a}, 1 = segment lit.
   // Letters follow the usual mixed-case forms: A b C d E F.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [7:0] seg_polarity(input logic [7:0] segHigh, input bit activeLow);
      return activeLow ? ~segHigh : segHigh;
   endfunction

   function automatic logic [7:0] sel_polarity(input logic [7:0] selHigh, input bit activeLow);
      return activeLow ? ~selHigh : selHigh;
   endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder
// Combinational hex nibble + decimal point -> 8-bit active-high segment vector.
// Board polarity is applied later, in the sequencer's output register.
// Ports:
//  nibble_i   [3:0]  hex value to show
//  dp_i              decimal point, 1 = lit
//  segHigh_o  [7:0]  [7] = DP, [6:0] = g..a, 1 = lit
module ssd_hex_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   output logic [7:0] segHigh_o
);

   assign segHigh_o = {dp_i, SEG_TABLE[nibble_i]};

endmodule

// File: rtl/ssd_scan_sequencer.sv
// ssd_scan_sequencer
// Time-multiplexes DIGITS seven-segment digits over one shared segment bus.
// Each digit owns a slot of PRESCALE cycles: BLANK_CYCLES dark cycles to stop
// ghosting while the bus switches, then SHOW. Display data lives in a shadow
// register reloaded only at the frame boundary, so a frame never mixes old and
// new data.
// Optional feature macro: SSD_DIMMING_EN (adds bright_i and PWM inside SHOW).
// Ports:
//  clk_i         system clock
//  rst_ni        asynchronous reset, active-low
//  data_i        hex nibble per digit, digit i = data_i[4i+3:4i]
//  dp_i          decimal point per digit, 1 = lit
//  digitEn_i     1 = digit displayed, 0 = dark (slot still consumed)
//  bright_i      (SSD_DIMMING_EN only) brightness 0..15, 15 = full SHOW duty
//  load_i        request to capture data/dp/enable at the next frame end
//  loadAck_o     1-cycle pulse on the first cycle after a capture
//  outputSeg_o   [7] = DP, [6:0] = g..a, polarity from SEG_ACTIVE_LOW
//  outputSel_o   one-hot digit select, polarity from SEL_ACTIVE_LOW
//  scanClk_o     1-cycle pulse on the first cycle of every slot
//  frameDone_o   1-cycle pulse on the last cycle of digit DIGITS-1
module ssd_scan_sequencer
   import ssd_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int PRESCALE       = 50000,
   parameter int BLANK_CYCLES   = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [4*DIGITS-1:0]   data_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic [DIGITS-1:0]     digitEn_i,
`ifdef SSD_DIMMING_EN
   input  logic [3:0]            bright_i,
`endif
   input  logic                  load_i,
   output logic                  loadAck_o,
   output logic [7:0]            outputSeg_o,
   output logic [DIGITS-1:0]     outputSel_o,
   output logic                  scanClk_o,
   output logic                  frameDone_o
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(DIGITS - 1);

   localparam scan_state_e SLOT_START_STATE = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

   localparam logic [7:0]        SEG_OFF = seg_polarity(8'h00, SEG_ACTIVE_LOW);
   localparam logic [DIGITS-1:0] SEL_OFF = DIGITS'(sel_polarity(8'h00, SEL_ACTIVE_LOW));

   // The counters and FSM run one cycle ahead of the registered outputs: the
   // values held here describe the cycle the output registers will show next.
   logic [CNT_W-1:0]    slotCnt_q,  slotCnt_d;
   logic [DIG_W-1:0]    digitIdx_q, digitIdx_d;
   scan_state_e         state_q,    state_d;

   logic [4*DIGITS-1:0] shData_q,   shData_d;
   logic [DIGITS-1:0]   shDp_q,     shDp_d;
   logic [DIGITS-1:0]   shEn_q,     shEn_d;
   logic [3:0]          shBright_q, shBright_d;

   logic [7:0]          seg_q,      seg_d;
   logic [DIGITS-1:0]   sel_q,      sel_d;
   logic                scan_q,     scan_d;
   logic                frame_q,    frame_d;
   logic                ack_q,      ack_d;

   logic                loadTake;
   logic                dimOk;
   logic                lit;
   logic [7:0]          decSeg;
   logic [DIGITS-1:0]   selOneHot;

   // A load is honoured only while FRAME_DONE is on the pins. The output
   // registers are loading the first cycle of digit 0 at that same edge, so
   // the decode path below reads the post-load shadow (the _d values).
   assign loadTake = frame_q & load_i;

   // Shadow next-state: either keep the current frame's data or take the
   // user inputs when a load is accepted.
   always_comb begin
      shData_d   = shData_q;
      shDp_d     = shDp_q;
      shEn_d     = shEn_q;
      shBright_d = shBright_q;
      if (loadTake) begin
         shData_d = data_i;
         shDp_d   = dp_i;
         shEn_d   = digitEn_i;
`ifdef SSD_DIMMING_EN
         shBright_d = bright_i;
`endif
      end
   end

   // Slot counter and digit index; every slot is exactly PRESCALE cycles so
   // the refresh rate never depends on which digits are enabled.
   always_comb begin
      slotCnt_d  = slotCnt_q + 1'b1;
      digitIdx_d = digitIdx_q;
      if (slotCnt_q == SLOT_LAST) begin
         slotCnt_d  = '0;
         digitIdx_d = (digitIdx_q == DIGIT_LAST) ? '0 : digitIdx_q + 1'b1;
      end
   end

   ssd_hex_decoder uDecoder (
      .nibble_i  (shData_d[{digitIdx_q, 2'b00} +: 4]),
      .dp_i      (shDp_d[digitIdx_q]),
      .segHigh_o (decSeg)
   );

   // Brightness PWM: only the first part of SHOW is lit, its length scaled by
   // (bright+1)/16 of the SHOW window.
`ifdef SSD_DIMMING_EN
   logic [31:0] showCnt;
   logic [31:0] dimLimit;
   assign showCnt  = 32'(slotCnt_q) - 32'(BLANK_CYCLES);
   assign dimLimit = (32'(PRESCALE - BLANK_CYCLES) * (32'(shBright_d) + 32'd1)) >> 4;
   assign dimOk    = (showCnt < dimLimit);
`else
   assign dimOk = 1'b1;
`endif

   // Slot FSM next state plus the next values of every registered output.
   always_comb begin
      state_d   = state_q;
      lit       = 1'b0;
      selOneHot = '0;
      seg_d     = SEG_OFF;
      sel_d     = SEL_OFF;
      scan_d    = (slotCnt_q == '0);
      frame_d   = (slotCnt_q == SLOT_LAST) && (digitIdx_q == DIGIT_LAST);
      ack_d     = loadTake;

      case (state_q)
         ST_BLANK: begin
            if (slotCnt_q == BLANK_LAST) begin
               state_d = ST_SHOW;
            end
         end
         ST_SHOW: begin
            lit = shEn_d[digitIdx_q] & dimOk;
            if (slotCnt_q == SLOT_LAST) begin
               state_d = SLOT_START_STATE;
            end
         end
         default: begin
            state_d = SLOT_START_STATE;
         end
      endcase

      if (lit) begin
         selOneHot = DIGITS'(1) << digitIdx_q;
         seg_d     = seg_polarity(decSeg, SEG_ACTIVE_LOW);
         sel_d     = DIGITS'(sel_polarity(8'(selOneHot), SEL_ACTIVE_LOW));
      end
   end

   // Timing state: counters and FSM. Async reset puts us at slot 0 of digit 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slotCnt_q  <= '0;
         digitIdx_q <= '0;
         state_q    <= SLOT_START_STATE;
      end else begin
         slotCnt_q  <= slotCnt_d;
         digitIdx_q <= digitIdx_d;
         state_q    <= state_d;
      end
   end

   // Shadow display data. Reset clears it so the display stays dark until
   // the first accepted load; brightness defaults to full.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shData_q   <= '0;
         shDp_q     <= '0;
         shEn_q     <= '0;
         shBright_q <= 4'hF;
      end else begin
         shData_q   <= shData_d;
         shDp_q     <= shDp_d;
         shEn_q     <= shEn_d;
         shBright_q <= shBright_d;
      end
   end

   // Output registers; polarity inversion already folded into seg_d/sel_d.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seg_q   <= SEG_OFF;
         sel_q   <= SEL_OFF;
         scan_q  <= 1'b0;
         frame_q <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         seg_q   <= seg_d;
         sel_q   <= sel_d;
         scan_q  <= scan_d;
         frame_q <= frame_d;
         ack_q   <= ack_d;
      end
   end

   assign outputSeg_o = seg_q;
   assign outputSel_o = sel_q;
   assign scanClk_o   = scan_q;
   assign frameDone_o = frame_q;
   assign loadAck_o   = ack_q;

endmodule

// File: tb/tb_ssd_scan_sequencer.sv
// tb_ssd_scan_sequencer
// Directed bench for ssd_scan_sequencer with PRESCALE=8, BLANK_CYCLES=2,
// DIGITS=4, both polarities active-low. Output cycle k of a frame is digit k/8,
// slot position k%8; positions 0-1 are blank, 2-7 show.
// Honours SSD_DIMMING_EN (bright_i port and a dimming scenario).
module tb_ssd_scan_sequencer;

`ifdef SSD_DIMMING_EN
   localparam bit DIM = 1'b1;
`else
   localparam bit DIM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [15:0] dataIn = '0;
   logic [3:0]  dpIn = '0;
   logic [3:0]  enIn = '0;
   logic [3:0]  brightIn = 4'hF;
   logic        loadIn = 1'b0;
   logic        loadAck;
   logic [7:0]  seg;
   logic [3:0]  sel;
   logic        scanClk;
   logic        frameDone;

   int total = 0;
   int bad   = 0;

   logic [3:0] seenSel [32];
   logic [7:0] seenSeg [32];

   ssd_scan_sequencer #(
      .DIGITS         (4),
      .PRESCALE       (8),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (1'b1),
      .SEL_ACTIVE_LOW (1'b1)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .data_i      (dataIn),
      .dp_i        (dpIn),
      .digitEn_i   (enIn),
`ifdef SSD_DIMMING_EN
      .bright_i    (brightIn),
`endif
      .load_i      (loadIn),
      .loadAck_o   (loadAck),
      .outputSeg_o (seg),
      .outputSel_o (sel),
      .scanClk_o   (scanClk),
      .frameDone_o (frameDone)
   );

   // 10 ns clock; checks happen on the falling edge.
   always #5 clk = ~clk;

   // Hand-written active-high g..a patterns for each hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   // Whether frame cycle k should have its digit lit.
   function automatic bit modelLit(input int k, input logic [3:0] en, input logic [3:0] bright);
      int d = k / 8;
      int s = k % 8;
      if (s < 2) return 1'b0;
      if (!en[d]) return 1'b0;
      if (DIM && ((s - 2) >= ((6 * (int'(bright) + 1)) >> 4))) return 1'b0;
      return 1'b1;
   endfunction

   // Walks one 32-cycle frame, starting on the negedge of cycle 0, checking
   // every output against the reference. load_i is set to holdLoad at k=0 and
   // optionally pulsed for one cycle at k=pulseK.
   task automatic scan_frame(input string tag, input logic [15:0] expData, input logic [3:0] expDp,
                             input logic [3:0] expEn, input logic [3:0] expBright, input bit expAck,
                             input bit holdLoad, input int pulseK);
      logic [3:0] one;
      logic [3:0] wantSel;
      logic [7:0] wantSeg;
      bit         wantAck;
      int         d;
      one = 4'b0001;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         d = k / 8;
         if (modelLit(k, expEn, expBright)) begin
            wantSel = ~(one << d);
            wantSeg = ~{expDp[d], hex7(expData[4*d +: 4])};
         end else begin
            wantSel = 4'hF;
            wantSeg = 8'hFF;
         end
         wantAck = (k == 0) && expAck;
         seenSel[k] = sel;
         seenSeg[k] = seg;
         total++;
         if (sel !== wantSel) begin
            bad++;
            $display("[TB] FAIL %s sel k=%0d got %b want %b", tag, k, sel, wantSel);
         end
         total++;
         if (seg !== wantSeg) begin
            bad++;
            $display("[TB] FAIL %s seg k=%0d got %h want %h", tag, k, seg, wantSeg);
         end
         total++;
         if (scanClk !== ((k % 8) == 0)) begin
            bad++;
            $display("[TB] FAIL %s scan_clk k=%0d got %b want %b", tag, k, scanClk, (k % 8) == 0);
         end
         total++;
         if (frameDone !== (k == 31)) begin
            bad++;
            $display("[TB] FAIL %s frame_done k=%0d got %b want %b", tag, k, frameDone, k == 31);
         end
         total++;
         if (loadAck !== wantAck) begin
            bad++;
            $display("[TB] FAIL %s load_ack k=%0d got %b want %b", tag, k, loadAck, wantAck);
         end
         if (k == 0) loadIn = holdLoad;
         if (k == pulseK) loadIn = 1'b1;
         if (k == pulseK + 1) loadIn = holdLoad;
      end
   endtask

   task automatic checkDark(input string tag);
      total++;
      if (sel !== 4'hF || seg !== 8'hFF || scanClk !== 1'b0 || frameDone !== 1'b0 || loadAck !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s got sel=%b seg=%h scan=%b frame=%b ack=%b want sel=1111 seg=ff pulses 0",
                  tag, sel, seg, scanClk, frameDone, loadAck);
      end
   endtask

   // Reset values, then release: first frame runs dark because shadow EN is 0.
   task automatic test_reset();
      rstN = 1'b0;
      repeat (3) @(negedge clk);
      checkDark("reset_hold");
      rstN = 1'b1;
      scan_frame("after_reset", 16'h0000, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, -1);
   endtask

   // Load 8421 at the first frame end; ack on digit 0's first cycle.
   task automatic test_load();
      dataIn = 16'h8421; enIn = 4'hF; dpIn = 4'h0; loadIn = 1'b1;
      scan_frame("load", 16'h8421, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, -1);
      total++;
      if (seenSel[2] !== 4'b1110 || seenSeg[2] !== 8'hF9) begin
         bad++;
         $display("[TB] FAIL load_digit0 got sel=%b seg=%h want sel=1110 seg=f9", seenSel[2], seenSeg[2]);
      end
      total++;
      if (seenSel[26] !== 4'b0111 || seenSeg[26] !== 8'h80) begin
         bad++;
         $display("[TB] FAIL load_digit3 got sel=%b seg=%h want sel=0111 seg=80", seenSel[26], seenSeg[26]);
      end
   endtask

   // Steady scanning: pulses and blanking repeat identically frame after frame.
   task automatic test_back_to_back();
      scan_frame("steady1", 16'h8421, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, -1);
      scan_frame("steady2", 16'h8421, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, -1);
   endtask

   // Digits 0 and 2 disabled: dark for whole slots, frame length unchanged.
   task automatic test_enable_mask();
      enIn = 4'b1010; loadIn = 1'b1;
      scan_frame("enable_mask", 16'h8421, 4'h0, 4'b1010, 4'hF, 1'b1, 1'b0, -1);
   endtask

   // Mid-frame load pulse is ignored; a held load reloads at every frame end.
   task automatic test_no_tear();
      dataIn = 16'h0000; enIn = 4'hF;
      scan_frame("midframe_pulse", 16'h8421, 4'h0, 4'b1010, 4'hF, 1'b0, 1'b0, 5);
      loadIn = 1'b1;
      scan_frame("held_load1", 16'h0000, 4'h0, 4'hF, 4'hF, 1'b1, 1'b1, -1);
      scan_frame("held_load2", 16'h0000, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, -1);
   endtask

   // Decimal point together with the letter F.
   task automatic test_decimal_point();
      dataIn = 16'h000F; dpIn = 4'b0001; enIn = 4'hF; loadIn = 1'b1;
      scan_frame("dp", 16'h000F, 4'b0001, 4'hF, 4'hF, 1'b1, 1'b0, -1);
      total++;
      if (seenSeg[2] !== 8'h0E) begin
         bad++;
         $display("[TB] FAIL dp_digit0 got %h want 0e", seenSeg[2]);
      end
      total++;
      if (seenSeg[10] !== 8'hC0) begin
         bad++;
         $display("[TB] FAIL dp_digit1 got %h want c0", seenSeg[10]);
      end
   endtask

   // Async reset in the middle of digit 2's SHOW, then dark after release.
   task automatic test_reset_mid();
      for (int k = 0; k <= 18; k++) @(negedge clk);
      total++;
      if (sel !== 4'b1011) begin
         bad++;
         $display("[TB] FAIL premid_sel got %b want 1011", sel);
      end
      #2 rstN = 1'b0;
      #1 checkDark("reset_mid_async");
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      scan_frame("after_mid_reset", 16'h0000, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, -1);
   endtask

`ifdef SSD_DIMMING_EN
   // Brightness 7: SHOW lit for 3 of its 6 cycles.
   task automatic test_dimming();
      dataIn = 16'h8421; dpIn = 4'h0; enIn = 4'hF; brightIn = 4'd7; loadIn = 1'b1;
      scan_frame("dim7", 16'h8421, 4'h0, 4'hF, 4'd7, 1'b1, 1'b0, -1);
      total++;
      if (seenSel[4] !== 4'b1110 || seenSel[5] !== 4'hF) begin
         bad++;
         $display("[TB] FAIL dim_window got sel4=%b sel5=%b want 1110 1111", seenSel[4], seenSel[5]);
      end
   endtask
`endif

   initial begin
      $display("[TB] start");
      test_reset();
      test_load();
      test_back_to_back();
      test_enable_mask();
      test_no_tear();
      test_decimal_point();
      test_reset_mid();
`ifdef SSD_DIMMING_EN
      test_dimming();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
